// File: rtl/stream_mux_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : stream_mux_pkg                                             |
// | Description : Shared definitions for the stream_mux block: mode          |
// |               encodings, default geometry and output-register states.    |
// | Ports       : none (package)                                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package stream_mux_pkg;

  // Value of the mode port
  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Default geometry
  localparam int DEFAULT_N_IN = 8;
  localparam int DEFAULT_W    = 8;

  // One-entry output register occupancy
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage : stream_mux_pkg
`default_nettype wire

// File: rtl/stream_mux_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rr_arbiter                                                 |
// | Description : Combinational round-robin search. Finds the first set      |
// |               request bit starting at ptr+1 and wrapping modulo N_IN.    |
// | Ports       : req[N_IN]      - request vector                            |
// |               ptr[SELW]      - index granted last (lowest priority now)  |
// |               grant[SELW]    - index of the winning request              |
// |               grant_valid    - high when any request is set              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module rr_arbiter #(
  parameter int N_IN = 8,
  parameter int SELW = $clog2(N_IN)
) (
  input  logic [N_IN-1:0] req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] grant,
  output logic            grant_valid
);

  logic [SELW-1:0] w_idx;

  // Walk the N_IN candidates in priority order; the first hit wins. ptr is
  // always a legal channel index, so the wrapped index stays below N_IN.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    w_idx       = '0;
    for (int k = 1; k <= N_IN; k++) begin
      w_idx = SELW'((int'(ptr) + k) % N_IN);
      if (!grant_valid && req[w_idx]) begin
        grant_valid = 1'b1;
        grant       = w_idx;
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/stream_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : stream_mux                                                 |
// | Description : N_IN-to-1 valid/ready stream multiplexer with a one-entry  |
// |               registered output. Select mode grants channel sel; the     |
// |               optional round-robin mode (compiled only when the macro    |
// |               STREAM_MUX_RR_EN is defined) rotates priority after each   |
// |               accepted word. Without the macro, mode is ignored.         |
// | Ports       : clk, rst (async, active high)                              |
// |               in_data[N_IN*W], in_valid[N_IN], in_ready[N_IN]            |
// |               sel[SELW], mode                                            |
// |               out_data[W], out_valid, out_ready, out_src[SELW]           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module stream_mux
  import stream_mux_pkg::*;
#(
  parameter int N_IN = DEFAULT_N_IN,
  parameter int W    = DEFAULT_W,
  parameter int SELW = $clog2(N_IN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_IN*W-1:0] in_data,
  input  logic [N_IN-1:0]   in_valid,
  output logic [N_IN-1:0]   in_ready,
  input  logic [SELW-1:0]   sel,
  input  logic              mode,
  output logic [W-1:0]      out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SELW-1:0]   out_src
);

  state_t          r_state;
  logic [W-1:0]    r_data;
  logic [SELW-1:0] r_src;

  logic            w_load;
  logic            w_sel_hit;
  logic            w_grant_valid;
  logic [SELW-1:0] w_grant;
  logic [W-1:0]    w_grant_data;
  logic            w_in_xfer;

  // The register can take a word when empty or when it is being drained this
  // cycle. Held low during reset so no handshake completes while rst is high.
  assign w_load = ~rst & ((r_state == ST_EMPTY) | out_ready);

  // Select-mode request check. Comparing against every legal index makes an
  // out-of-range sel (non power-of-two N_IN) naturally produce no grant.
  always_comb begin
    w_sel_hit = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      if ((sel == SELW'(i)) && in_valid[i]) begin
        w_sel_hit = 1'b1;
      end
    end
  end

`ifdef STREAM_MUX_RR_EN
  logic [SELW-1:0] r_ptr;
  logic [SELW-1:0] w_rr_grant;
  logic            w_rr_valid;

  rr_arbiter #(
    .N_IN (N_IN),
    .SELW (SELW)
  ) u_rr_arbiter (
    .req         (in_valid),
    .ptr         (r_ptr),
    .grant       (w_rr_grant),
    .grant_valid (w_rr_valid)
  );

  always_comb begin
    if (mode == MODE_RR) begin
      w_grant       = w_rr_grant;
      w_grant_valid = w_rr_valid;
    end else begin
      w_grant       = sel;
      w_grant_valid = w_sel_hit;
    end
  end

  // Reset value N_IN-1 makes channel 0 the first candidate after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= SELW'(N_IN - 1);
    end else if (w_in_xfer && (mode == MODE_RR)) begin
      r_ptr <= w_grant;
    end
  end
`else
  logic w_unused_mode;
  assign w_unused_mode = mode;

  assign w_grant       = sel;
  assign w_grant_valid = w_sel_hit;
`endif

  assign w_in_xfer = w_grant_valid & w_load;

  // One-hot ready and data steering for the granted channel.
  always_comb begin
    in_ready     = '0;
    w_grant_data = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (w_grant == SELW'(i)) begin
        in_ready[i]  = w_grant_valid & w_load;
        w_grant_data = in_data[i*W +: W];
      end
    end
  end

  // Output register: a new word wins over a drain in the same cycle, which
  // keeps the register FULL at one transfer per clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_data  <= '0;
      r_src   <= '0;
    end else if (w_in_xfer) begin
      r_state <= ST_FULL;
      r_data  <= w_grant_data;
      r_src   <= w_grant;
    end else if (out_ready) begin
      r_state <= ST_EMPTY;
    end
  end

  assign out_valid = (r_state == ST_FULL);
  assign out_data  = r_data;
  assign out_src   = r_src;

endmodule : stream_mux
`default_nettype wire

// File: tb/tb_stream_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_stream_mux                                              |
// | Description : Self-checking bench for stream_mux (N_IN=8, W=8). Round-   |
// |               robin sequences run only when STREAM_MUX_RR_EN is defined. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_stream_mux;
  import stream_mux_pkg::*;

  localparam int N  = 8;
  localparam int DW = 8;
  localparam int SW = 3;
`ifdef STREAM_MUX_RR_EN
  localparam bit RR_BUILT = 1'b1;
`else
  localparam bit RR_BUILT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_ready;
  logic [SW-1:0] sel;
  logic          mode;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_src;

  int checks   = 0;
  int failures = 0;

  // Reference model: a one-deep buffer plus the last round-robin winner
  bit            m_full;
  logic [DW-1:0] m_data;
  int            m_src;
  int            m_ptr;

  typedef struct {
    logic          md;
    logic [SW-1:0] s;
    logic [N-1:0]  v;
    logic          ordy;
    logic [N-1:0]  e_rdy;
    logic          e_ov;
    logic [DW-1:0] e_data;
    logic [SW-1:0] e_src;
  } vec_t;

  vec_t vecs[7];

  stream_mux #(.N_IN(N), .W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .mode      (mode),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_src   (out_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Granted channel from the rules, or -1 when nothing is granted
  function automatic int model_grant();
    int p;
    if (RR_BUILT && mode == MODE_RR) begin
      for (int k = 1; k <= N; k++) begin
        p = (m_ptr + k) % N;
        if (in_valid[p]) return p;
      end
      return -1;
    end
    if (int'(sel) < N && in_valid[sel]) return int'(sel);
    return -1;
  endfunction

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    int g;
    r = '0;
    g = model_grant();
    if (g >= 0 && (!m_full || out_ready)) r[g] = 1'b1;
    return r;
  endfunction

  // Called just after a rising edge with the inputs that were applied to it
  task automatic model_edge(input int g, input bit load);
    if (g >= 0 && load) begin
      m_full = 1'b1;
      m_data = in_data[g*DW +: DW];
      m_src  = g;
      if (RR_BUILT && mode == MODE_RR) m_ptr = g;
    end else if (out_ready) begin
      m_full = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_full = 1'b0;
    m_data = '0;
    m_src  = 0;
    m_ptr  = N - 1;
  endtask

  // One clock against the model: check ready before the edge, outputs after
  task automatic step(input string tag);
    int g;
    bit load;
    #1;
    chk({tag, " in_ready"}, in_ready, model_ready());
    g    = model_grant();
    load = !m_full || out_ready;
    @(posedge clk);
    model_edge(g, load);
    #1;
    chk({tag, " out_valid"}, out_valid, m_full);
    if (m_full) begin
      chk({tag, " out_data"}, out_data, m_data);
      chk({tag, " out_src"}, out_src, m_src);
    end
  endtask

  task automatic set_default_data();
    for (int i = 0; i < N; i++) in_data[i*DW +: DW] = 8'(8'hA2 + i);
  endtask

  initial begin
    int g;
    bit load;

    vecs[0] = '{1'b0, 3'd3, 8'hFF, 1'b1, 8'h08, 1'b1, 8'hA5, 3'd3};
    vecs[1] = '{1'b0, 3'd5, 8'hFF, 1'b0, 8'h00, 1'b1, 8'hA5, 3'd3};
    vecs[2] = '{1'b0, 3'd5, 8'hFF, 1'b1, 8'h20, 1'b1, 8'hA7, 3'd5};
    vecs[3] = '{1'b0, 3'd3, 8'hF7, 1'b1, 8'h00, 1'b0, 8'h00, 3'd0};
    vecs[4] = '{1'b0, 3'd3, 8'hF7, 1'b0, 8'h00, 1'b0, 8'h00, 3'd0};
    vecs[5] = '{1'b0, 3'd0, 8'h01, 1'b0, 8'h01, 1'b1, 8'hA2, 3'd0};
    vecs[6] = '{1'b0, 3'd0, 8'h01, 1'b0, 8'h00, 1'b1, 8'hA2, 3'd0};

    set_default_data();
    rst = 1'b1; mode = MODE_SEL; sel = 3'd3; in_valid = 8'hFF; out_ready = 1'b1;
    model_reset();

    // Reset state and no handshake while reset is held
    #1;
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data", out_data, 0);
    chk("reset out_src", out_src, 0);
    chk("reset in_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("reset no xfer", out_valid, 0);
    rst = 1'b0;

    // Table-driven select-mode vectors
    for (int i = 0; i < 7; i++) begin
      mode = vecs[i].md; sel = vecs[i].s; in_valid = vecs[i].v; out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("vec%0d in_ready", i), in_ready, vecs[i].e_rdy);
      g    = model_grant();
      load = !m_full || out_ready;
      @(posedge clk);
      model_edge(g, load);
      #1;
      chk($sformatf("vec%0d out_valid", i), out_valid, vecs[i].e_ov);
      if (vecs[i].e_ov) begin
        chk($sformatf("vec%0d out_data", i), out_data, vecs[i].e_data);
        chk($sformatf("vec%0d out_src", i), out_src, vecs[i].e_src);
      end
    end

    // Backpressure: held word A2/0 must stay while the sink stalls
    sel = 3'd3; in_valid = 8'hFF; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step("stall");
      chk("stall in_ready", in_ready, 0);
      chk("stall data held", out_data, 8'hA2);
      chk("stall src held", out_src, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("release in_ready", in_ready, 8'h08);
    step("release");
    chk("release next word", out_data, 8'hA5);

`ifndef STREAM_MUX_RR_EN
    // mode is ignored: still grants sel
    mode = MODE_RR; sel = 3'd2;
    step("mode ignored");
    chk("mode ignored src", out_src, 2);
    mode = MODE_SEL;
`endif

    // Reset in the middle of a FULL word
    rst = 1'b1;
    #1;
    chk("midreset out_valid", out_valid, 0);
    chk("midreset out_data", out_data, 0);
    model_reset();
    @(posedge clk); #1;
    chk("midreset no xfer", out_valid, 0);
    rst = 1'b0;

`ifdef STREAM_MUX_RR_EN
    // Round-robin sweep from reset: 0..7 then wrap to 0
    mode = MODE_RR; in_valid = 8'hFF; out_ready = 1'b1;
    for (int i = 0; i <= N; i++) begin
      step("rr sweep");
      chk($sformatf("rr sweep src%0d", i), out_src, i % N);
    end

    // Sparse requests after ptr lands on 6
    rst = 1'b1; model_reset(); #1; rst = 1'b0;
    in_valid = 8'h40;
    step("rr to6");
    chk("rr ptr6 src", out_src, 6);
    in_valid = 8'b0000_0101;
    step("rr sparse"); chk("rr sparse a", out_src, 0);
    step("rr sparse"); chk("rr sparse b", out_src, 2);
    step("rr sparse"); chk("rr sparse c", out_src, 0);
`endif

    // Randomised traffic against the model
    rst = 1'b1; model_reset(); #1; rst = 1'b0;
    for (int c = 0; c < 400; c++) begin
      mode      = ($urandom_range(0, 3) == 0) ? ~mode : mode;
      sel       = SW'($urandom_range(0, N - 1));
      in_valid  = ($urandom_range(0, 1) == 0) ? N'($urandom) : N'($urandom & $urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 0) in_data = {$urandom, $urandom};
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_stream_mux
`default_nettype wire
